// File: rtl/mx_format_pkg.sv
// Shared MX format constants, packer FSM states and packed MXFP8 block types.
package mx_format_pkg;

    localparam int MX_K = 32;

    localparam int         E5M2_BIAS        = 15;
    localparam int         E5M2_EMAX        = 15;
    localparam logic [7:0] E8M0_NAN         = 8'hFF;
    localparam logic [6:0] E5M2_MAXNORM_MAG = 7'h7B;

    typedef enum logic [1:0] {
        COLLECT,
        QUANT,
        OUT
    } packer_state_e;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [1:0] mant;
    } mxfp8_e5m2_element;

    typedef struct packed {
        logic [7:0]                         scale;
        mxfp8_e5m2_element [MX_K-1:0]       elem;
    } mxfp8_block;

endpackage

// File: rtl/mx_fp32_to_e5m2.sv
// Combinational FP32 -> E5M2 element quantizer against a shared E8M0 scale.
module mx_fp32_to_e5m2
    import mx_format_pkg::*;
(
    input  logic [31:0] fp32,
    input  logic [7:0]  scale,
    output logic [7:0]  elem
);

    logic        sign;
    logic [7:0]  e;
    logic [22:0] m;
    int          t;
    int          sh;
    logic [49:0] ext;
    logic        rnd;
    logic [7:0]  mag8;
    logic [6:0]  mag;

    always_comb begin
        sign = fp32[31];
        e    = fp32[30:23];
        m    = fp32[22:0];
        t    = int'(e) - int'(scale) + E5M2_BIAS;
        sh   = 1 - t;
        ext  = '0;
        rnd  = 1'b0;
        mag8 = '0;
        mag  = '0;
        if (scale == E8M0_NAN) begin
            elem = 8'h00;
        end else if (e == 8'd0) begin
            elem = {sign, 7'd0};
        end else begin
            if (t >= 1) begin
                if (t >= 31) begin
                    mag = E5M2_MAXNORM_MAG;
                end else begin
                    rnd  = m[20] & (m[21] | (|m[19:0]));
                    mag8 = {1'b0, t[4:0], m[22:21]} + {7'd0, rnd};
                    // A rounding carry into exponent 31 would be Inf.
                    if (mag8[6:2] == 5'd31)
                        mag = E5M2_MAXNORM_MAG;
                    else
                        mag = mag8[6:0];
                end
            end else if (sh < 26) begin
                // Significand placed so bits [48:47] are the kept mantissa.
                ext  = {1'b1, m, 26'd0} >> sh;
                rnd  = ext[46] & (ext[47] | (|ext[45:0]));
                mag8 = {5'd0, ext[49:47]} + {7'd0, rnd};
                mag  = mag8[6:0];
            end
            elem = {sign, mag};
        end
    end

endmodule

// File: rtl/mx_block_packer.sv
// Streaming FP32 -> MXFP8 (E5M2) block encoder: collect K, quantize, emit.
module mx_block_packer
    import mx_format_pkg::*;
#(
    parameter int K = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8+8*K-1:0]  out_block
);

    localparam int SIZE = 8 + 8 * K;
    localparam int CW   = $clog2(K);

    packer_state_e state_q;
    packer_state_e state_d;

    logic [CW-1:0] cnt;
    logic [CW-1:0] qi;
    logic [7:0]    max_exp;
    logic          nan_seen;
    logic [31:0]   slots [K];

    logic          accept;
    logic          last_in;
    logic          last_q;
    logic [7:0]    exp_in;
    logic [7:0]    max_nxt;
    logic          nan_nxt;
    logic [7:0]    scale_nxt;
    logic [7:0]    elem;

    mx_fp32_to_e5m2 u_conv (
        .fp32  (slots[qi]),
        .scale (out_block[SIZE-1 -: 8]),
        .elem  (elem)
    );

    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == OUT);
        accept    = in_valid && in_ready;
        last_in   = (cnt == CW'(K - 1));
        last_q    = (qi == CW'(K - 1));
        exp_in    = in_data[30:23];
        max_nxt   = (exp_in > max_exp) ? exp_in : max_exp;
        nan_nxt   = nan_seen | (exp_in == 8'hFF);
        // E8M0 and FP32 share bias 127, so only the E5M2 emax offset applies.
        if (nan_nxt)
            scale_nxt = E8M0_NAN;
        else if (max_nxt <= 8'(E5M2_EMAX))
            scale_nxt = 8'd0;
        else
            scale_nxt = max_nxt - 8'(E5M2_EMAX);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept && last_in) state_d = QUANT;
            QUANT:   if (last_q)            state_d = OUT;
            OUT:     if (out_ready)         state_d = COLLECT;
            default:                        state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= COLLECT;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            qi        <= '0;
            max_exp   <= '0;
            nan_seen  <= 1'b0;
            out_block <= '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        cnt      <= cnt + 1'b1;
                        max_exp  <= max_nxt;
                        nan_seen <= nan_nxt;
                        if (last_in)
                            out_block[SIZE-1 -: 8] <= scale_nxt;
                    end
                end
                QUANT: begin
                    out_block[{qi, 3'b000} +: 8] <= elem;
                    qi <= last_q ? '0 : qi + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        cnt      <= '0;
                        max_exp  <= '0;
                        nan_seen <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: cnt gates which slots are valid.
    always_ff @(posedge clk) begin
        if (accept)
            slots[cnt] <= in_data;
    end

endmodule
